vga_tile_renderer: RTL and testbench

Parametrised VGA tile renderer for the tetris display path: it generates 640x480@60 timing from the 25 MHz pixel clock and fetches one cell index per tile from external synchronous board RAM. It maps that index through a writable colour palette and drives aligned 12-bit RGB with hsync and vsync. It is the multi-colour, multi-geometry successor of the single-bit cell renderer: it adds a border colour, optional grid lines, a data-enable output and a frame-start strobe.

---
 rtl/vga_tile_renderer_if.sv | 31 +++
 rtl/vga_tile_renderer.sv | 161 ++++++++++++++++
 tb/tb_vga_tile_renderer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vga_tile_renderer_if.sv
// Signal bundle between the tile renderer, its board RAM, the palette writer
// and the video output stage.
interface vga_tile_renderer_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 3
);
    // No valid/ready pairs here. cell_addr is a free-running read address.
    // cell_idx must return the cell for that address exactly one cycle later.
    // pal_we is a single-cycle write strobe that is always accepted.
    // The video outputs carry a new pixel on every clock.
    logic [IDX_W-1:0]  cell_idx;
    logic              pal_we;
    logic [IDX_W-1:0]  pal_addr;
    logic [11:0]       pal_data;
    logic [ADDR_W-1:0] cell_addr;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic [11:0]       rgb;
    logic              frame_start;

    modport master (
        input  cell_idx, pal_we, pal_addr, pal_data,
        output cell_addr, hsync, vsync, de, rgb, frame_start
    );

    modport slave (
        output cell_idx, pal_we, pal_addr, pal_data,
        input  cell_addr, hsync, vsync, de, rgb, frame_start
    );
endinterface

// File: rtl/vga_tile_renderer.sv
// VGA tile renderer: raster timing, cell RAM fetch, palette lookup and aligned
// RGB/sync/de output, with a fixed 3-cycle pipeline from counters to pins.
module vga_tile_renderer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int CELL_SHIFT = 4,
    parameter int GRID_W = 10,
    parameter int GRID_H = 20,
    parameter int X0 = 240,
    parameter int Y0 = 80,
    parameter int ADDR_W = 8,
    parameter int IDX_W = 3,
    parameter logic [11:0] BORDER_COLOR = 12'h222,
    parameter int GRID_LINES = 0,
    parameter logic [11:0] LINE_COLOR = 12'h444
) (
    input  logic                clk_25mhz,
    input  logic                reset,
    vga_tile_renderer_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int PAL_N = 1 << IDX_W;

    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_E = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] GX_BEG  = HW'(X0);
    localparam logic [HW-1:0] GX_END  = HW'(X0 + (GRID_W << CELL_SHIFT));
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_E = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] GY_BEG  = VW'(Y0);
    localparam logic [VW-1:0] GY_END  = VW'(Y0 + (GRID_H << CELL_SHIFT));

    // Stage 0: raster counters
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_hcnt == H_LAST) begin
            r_hcnt <= '0;
            r_vcnt <= (r_vcnt == V_LAST) ? '0 : r_vcnt + VW'(1);
        end else begin
            r_hcnt <= r_hcnt + HW'(1);
        end
    end

    logic              w_act0, w_hs0, w_vs0, w_grid0, w_line0, w_fs0;
    logic [HW-1:0]     w_lx;
    logic [VW-1:0]     w_ly;
    logic [ADDR_W-1:0] w_addr0;

    always_comb begin
        w_act0  = (r_hcnt < H_ACT_E) && (r_vcnt < V_ACT_E);
        w_hs0   = !((r_hcnt >= HS_BEG) && (r_hcnt < HS_END));
        w_vs0   = !((r_vcnt >= VS_BEG) && (r_vcnt < VS_END));
        w_grid0 = (r_hcnt >= GX_BEG) && (r_hcnt < GX_END) &&
                  (r_vcnt >= GY_BEG) && (r_vcnt < GY_END);
        w_fs0   = (r_hcnt == '0) && (r_vcnt == '0);
        w_lx    = r_hcnt - GX_BEG;
        w_ly    = r_vcnt - GY_BEG;
        w_line0 = (GRID_LINES != 0) &&
                  ((w_lx[CELL_SHIFT-1:0] == '0) || (w_ly[CELL_SHIFT-1:0] == '0));
        w_addr0 = '0;
        if (w_grid0) begin
            w_addr0 = ADDR_W'(32'(w_ly >> CELL_SHIFT) * GRID_W + 32'(w_lx >> CELL_SHIFT));
        end
    end

    // Palette: writes land on the edge, so a lookup in the same cycle sees the old entry
    logic [11:0] r_pal [PAL_N];

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            for (int i = 0; i < PAL_N; i++) begin
                r_pal[i] <= (i == 0) ? 12'h000 : 12'h0FF;
            end
        end else if (vid.pal_we) begin
            r_pal[vid.pal_addr] <= vid.pal_data;
        end
    end

    logic [ADDR_W-1:0] r_cell_addr;
    logic r_act1, r_grid1, r_line1, r_hs1, r_vs1, r_fs1;
    logic r_act2, r_grid2, r_line2, r_hs2, r_vs2, r_fs2;
    logic [11:0] r_rgb;
    logic r_de, r_hsync, r_vsync, r_frame_start;
    logic [11:0] w_rgb2;

    always_comb begin
        w_rgb2 = 12'h000;
        if (!r_act2)       w_rgb2 = 12'h000;
        else if (!r_grid2) w_rgb2 = BORDER_COLOR;
        else if (r_line2)  w_rgb2 = LINE_COLOR;
        else               w_rgb2 = r_pal[vid.cell_idx];
    end

    // Sync flags travel active-low so their cleared state is "not in sync"
    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            r_cell_addr   <= '0;
            r_act1        <= 1'b0;
            r_grid1       <= 1'b0;
            r_line1       <= 1'b0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
            r_fs1         <= 1'b0;
            r_act2        <= 1'b0;
            r_grid2       <= 1'b0;
            r_line2       <= 1'b0;
            r_hs2         <= 1'b1;
            r_vs2         <= 1'b1;
            r_fs2         <= 1'b0;
            r_rgb         <= 12'h000;
            r_de          <= 1'b0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_cell_addr   <= w_addr0;
            r_act1        <= w_act0;
            r_grid1       <= w_grid0;
            r_line1       <= w_line0;
            r_hs1         <= w_hs0;
            r_vs1         <= w_vs0;
            r_fs1         <= w_fs0;
            r_act2        <= r_act1;
            r_grid2       <= r_grid1;
            r_line2       <= r_line1;
            r_hs2         <= r_hs1;
            r_vs2         <= r_vs1;
            r_fs2         <= r_fs1;
            r_rgb         <= w_rgb2;
            r_de          <= r_act2;
            r_hsync       <= r_hs2;
            r_vsync       <= r_vs2;
            r_frame_start <= r_fs2;
        end
    end

    assign vid.cell_addr   = r_cell_addr;
    assign vid.rgb         = r_rgb;
    assign vid.de          = r_de;
    assign vid.hsync       = r_hsync;
    assign vid.vsync       = r_vsync;
    assign vid.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer on a shrunken raster, with and
// without grid lines, including palette writes and a mid-frame reset.
module tb_vga_tile_renderer;
    localparam int HA = 64, HF = 4, HS = 8, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 48, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
    localparam int CS = 2, CELL = 1 << CS;
    localparam int GW = 10, GH = 8, X0 = 12, Y0 = 6;
    localparam int AW = 7, IW = 3;
    localparam logic [11:0] BORDER = 12'h222;
    localparam logic [11:0] LINE   = 12'h444;
    localparam logic [15:0] RST_ENT = {1'b0, 1'b1, 1'b1, 1'b0, 12'h000};
    localparam logic [11:0] INIT_PAL [8] = '{12'h000, 12'hF80, 12'h0F0, 12'h00F,
                                             12'hFF0, 12'hF0F, 12'h5A3, 12'hABC};

    logic clk;
    logic reset;
    logic pal_we;
    logic [IW-1:0] pal_addr;
    logic [11:0] pal_data;

    vga_tile_renderer_if #(.ADDR_W(AW), .IDX_W(IW)) bus0 ();
    vga_tile_renderer_if #(.ADDR_W(AW), .IDX_W(IW)) bus1 ();

    assign bus0.pal_we = pal_we;
    assign bus0.pal_addr = pal_addr;
    assign bus0.pal_data = pal_data;
    assign bus1.pal_we = pal_we;
    assign bus1.pal_addr = pal_addr;
    assign bus1.pal_data = pal_data;

    vga_tile_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_SHIFT(CS), .GRID_W(GW), .GRID_H(GH), .X0(X0), .Y0(Y0),
        .ADDR_W(AW), .IDX_W(IW), .BORDER_COLOR(BORDER), .GRID_LINES(0), .LINE_COLOR(LINE)
    ) u_dut0 (
        .clk_25mhz(clk),
        .reset(reset),
        .vid(bus0.master)
    );

    vga_tile_renderer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CELL_SHIFT(CS), .GRID_W(GW), .GRID_H(GH), .X0(X0), .Y0(Y0),
        .ADDR_W(AW), .IDX_W(IW), .BORDER_COLOR(BORDER), .GRID_LINES(1), .LINE_COLOR(LINE)
    ) u_dut1 (
        .clk_25mhz(clk),
        .reset(reset),
        .vid(bus1.master)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Board RAM: registered read, one cycle latency
    logic [IW-1:0] ram [2**AW];
    always @(posedge clk) begin
        bus0.cell_idx <= ram[bus0.cell_addr];
        bus1.cell_idx <= ram[bus1.cell_addr];
    end

    // Reference model
    logic [11:0] pal_m [2**IW];
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [AW-1:0] addr_q0[$];
    logic [AW-1:0] addr_q1[$];
    int n;
    bit run;
    int n_checks;
    int n_pass;

    function automatic bit in_grid(int x, int y);
        return (x >= X0) && (x < X0 + GW * CELL) && (y >= Y0) && (y < Y0 + GH * CELL);
    endfunction

    function automatic int cell_of(int x, int y);
        return ((y - Y0) / CELL) * GW + (x - X0) / CELL;
    endfunction

    function automatic logic [15:0] exp_pix(int x, int y, bit gl);
        bit act, hs, vs, fs;
        logic [11:0] c;
        act = (x < HA) && (y < VA);
        hs = !((x >= HA + HF) && (x < HA + HF + HS));
        vs = !((y >= VA + VF) && (y < VA + VF + VS));
        fs = (x == 0) && (y == 0);
        if (!act) c = 12'h000;
        else if (!in_grid(x, y)) c = BORDER;
        else if (gl && ((((x - X0) % CELL) == 0) || (((y - Y0) % CELL) == 0))) c = LINE;
        else c = pal_m[ram[cell_of(x, y)]];
        return {fs, hs, vs, act, c};
    endfunction

    function automatic logic [AW-1:0] exp_addr(int x, int y);
        if (in_grid(x, y)) return AW'(cell_of(x, y));
        return '0;
    endfunction

    // Called in the first cycle after the last edge that sampled reset high
    task automatic start_model();
        for (int i = 0; i < 2**IW; i++) pal_m[i] = (i == 0) ? 12'h000 : 12'h0FF;
        exp_q0.delete();
        exp_q1.delete();
        addr_q0.delete();
        addr_q1.delete();
        exp_q0.push_back(RST_ENT);
        exp_q1.push_back(RST_ENT);
        addr_q0.push_back('0);
        addr_q1.push_back('0);
        n = 0;
        run = 1'b1;
    endtask

    // Driver: one pixel clock. Pushes the output expected next cycle, then
    // drives an optional palette write that lands on the coming edge.
    task automatic cycle_body(input bit do_we, input logic [IW-1:0] wa, input logic [11:0] wd);
        int m;
        m = n - 2;
        if (m < 0) begin
            exp_q0.push_back(RST_ENT);
            exp_q1.push_back(RST_ENT);
        end else begin
            exp_q0.push_back(exp_pix(m % HT, (m / HT) % VT, 1'b0));
            exp_q1.push_back(exp_pix(m % HT, (m / HT) % VT, 1'b1));
        end
        addr_q0.push_back(exp_addr(n % HT, (n / HT) % VT));
        addr_q1.push_back(exp_addr(n % HT, (n / HT) % VT));
        pal_we = do_we;
        pal_addr = wa;
        pal_data = wd;
        if (do_we) pal_m[wa] = wd;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic random_cycle(input bit allow_we);
        cycle_body(allow_we && ($urandom_range(0, 31) == 0), IW'($urandom), 12'($urandom));
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got {fs,hs,vs,de,rgb}=%h expected=%h", name, n, act, exp);
    endtask

    task automatic check_addr(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle=%0d got cell_addr=%0d expected=%0d", name, n, act, exp);
    endtask

    // Monitor: outputs present every cycle; compare away from the rising edge
    always @(negedge clk) begin
        if (run) begin
            if (exp_q0.size() == 0 || exp_q1.size() == 0 || addr_q0.size() == 0 || addr_q1.size() == 0) begin
                n_checks++;
                $display("FAIL queue_underflow cycle=%0d got empty expected entry", n);
            end else begin
                check16("out_plain", {bus0.frame_start, bus0.hsync, bus0.vsync, bus0.de, bus0.rgb},
                        exp_q0.pop_front());
                check16("out_lines", {bus1.frame_start, bus1.hsync, bus1.vsync, bus1.de, bus1.rgb},
                        exp_q1.pop_front());
                check_addr("addr_plain", bus0.cell_addr, addr_q0.pop_front());
                check_addr("addr_lines", bus1.cell_addr, addr_q1.pop_front());
            end
        end
    end

    // Stimulus
    initial begin
        n_checks = 0;
        n_pass = 0;
        run = 1'b0;
        n = 0;
        reset = 1'b1;
        pal_we = 1'b0;
        pal_addr = '0;
        pal_data = '0;
        for (int i = 0; i < 2**AW; i++) ram[i] = IW'($urandom);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start_model();

        // Load seven distinct colours, then run with sparse random writes
        for (int k = 1; k < 8; k++) cycle_body(1'b1, IW'(k), INIT_PAL[k]);
        while (n < HT * VT + 20 * HT + 30) begin
            if (n == 20 * HT + 32) cycle_body(1'b1, IW'(3), 12'hF00);
            else random_cycle(1'b1);
        end

        // One-cycle reset in the middle of the second frame
        reset = 1'b1;
        pal_we = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start_model();

        // Default palette must be visible for a full frame before new writes
        while (n < 2 * HT * VT + 50) random_cycle(n >= HT * VT);

        run = 1'b0;
        pal_we = 1'b0;
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
